stacker_datapath: RTL and testbench
===================================

// Module: stacker_datapath
// PURPOSE
//  Datapath for the block-stacker game; sits directly under the stacker control FSM and serves as its execution stage.
//  - Holds the moving block's base position and sweep direction.
//  - Runs the frame-delay counter and the per-pixel plot counter.
//  - Drives x/y/colour to the 160x120 VGA adapter.
//  - Returns done_plot, enable_erase and stop_true to the FSM.
// PARAMETERS
//  BLOCK_W    16      block width in pixels, power of 2, 2..64
//  BLOCK_H    4       block height in pixels, power of 2, 1..16
//  SCREEN_W   160     screen width in pixels
//  SCREEN_H   120     screen height in pixels
//  X_STEP     1       pixels moved per UPDATE, must be < SCREEN_W-BLOCK_W
//  FRAME_DIV  833333  enable_counter cycles per movement step, >= 2
// PORTS
//  clk                  in   1  system clock
//  resetn               in   1  synchronous active-low reset
//  reset_counter        in   1  active-low clear of frame-delay counter
//  enable_counter       in   1  frame-delay counter increment enable
//  reset_load           in   1  active-low reload of start position, also clears game state
//  ld_x                 in   1  apply horizontal update
//  ld_y                 in   1  apply vertical update / consume stop request
//  count_x_enable       in   1  advance pixel counter (plot or erase pass)
//  colour_erase_enable  in   1  force output colour to 3'b000
//  stop_in              in   1  player button, already synchronised, active-high
//  colour_in            in   3  block colour
//  x                    out  8  pixel x = base_x + px
//  y                    out  7  pixel y = base_y + py
//  colour               out  3  colour_erase_enable ? 0 : colour_in
//  done_plot            out  1  last pixel of the block is being written this cycle
//  enable_erase         out  1  one-cycle pulse when the frame delay expires
//  stop_true            out  1  pending stop request
//  game_over            out  1  sticky flag: stack reached the top row
// BEHAVIOUR
//  Reset (resetn=0, or reset_load=0)
//   - base_x=0, base_y=SCREEN_H-BLOCK_H, dir=right.
//   - px=py=0, stop_req=0, game_over=0.
//  resetn=0 also clears the delay counter.
//  Either reset mid-plot aborts the pass with no residual px/py.
//  Output values under reset:
//   - x=0, y=SCREEN_H-BLOCK_H.
//   - done_plot=0, enable_erase=0, stop_true=0.
//   - colour is combinational and follows colour_in.
//  Frame-delay counter dcnt (20 bits)
//   - reset_counter=0 -> dcnt=0; this has priority over enable_counter.
//   - enable_counter=1 -> dcnt+1.
//   - At dcnt==FRAME_DIV-1 with enable_counter=1: enable_erase=1 (combinational, single cycle) and dcnt wraps to 0.
//  Pixel counter px/py
//   - count_x_enable=0 -> px=py=0.
//   - count_x_enable=1 -> px increments; at BLOCK_W-1 px wraps to 0 and py increments.
//   - done_plot = count_x_enable & px==BLOCK_W-1 & py==BLOCK_H-1 (combinational).
//   - On the done_plot cycle both counters return to 0.
//   - Exactly BLOCK_W*BLOCK_H writes per pass; latency from enable to done_plot = BLOCK_W*BLOCK_H-1 cycles.
//  x and y are combinational from registers, so they are valid in the same cycle as writeEn.
//  stop_req
//   - Set on a rising edge of stop_in (1-cycle delayed copy of stop_in).
//   - Cleared on ld_y=1; a set arriving in the same cycle as the clear wins.
//   - Ignored while game_over=1.
//  Update, on posedge when ld_x|ld_y, using pre-update stop_req:
//   - stop_req=1 and ld_y: base_x=0, dir=right.
//     - If base_y>=BLOCK_H: base_y -= BLOCK_H.
//     - Otherwise base_y is held and game_over is set.
//   - stop_req=0 and ld_x, moving right:
//     - If base_x+BLOCK_W+X_STEP <= SCREEN_W: base_x += X_STEP.
//     - Otherwise dir=left and base_x -= X_STEP.
//   - stop_req=0 and ld_x, moving left:
//     - If base_x >= X_STEP: base_x -= X_STEP.
//     - Otherwise dir=right and base_x += X_STEP.
//   - ld_x alone never touches y; ld_y alone with stop_req=0 is a no-op.
//  All arithmetic is unsigned at 8/7 bits; base_x+BLOCK_W-1 < SCREEN_W is invariant.
// STRUCTURE
//  Package stacker_pkg holds:
//   - SCREEN_W/SCREEN_H defaults and the X_W=8, Y_W=7 widths.
//   - The colour localparams BLACK=3'b000.
//   - The direction encoding DIR_RIGHT=1'b0, DIR_LEFT=1'b1.
//  Sub-module block_pixel_counter (params BLOCK_W, BLOCK_H; ports clk, resetn, clr_n, en -> px, py, last).
//  The delay counter, stop latch and position logic stay inline.
// TESTING
//  1. Reset, then count_x_enable=1 for 64 cycles (16x4) -> x runs 0..15 per row, y runs 116..119, done_plot only on cycle 64, colour=colour_in.
//  2. Same pass with colour_erase_enable=1 -> colour=0 on all 64 writes.
//  3. FRAME_DIV=5, enable_counter held high -> enable_erase pulses on cycles 5, 10, 15; reset_counter=0 at cycle 3 delays the next pulse to cycle 8.
//  4. base_x=143 moving right, X_STEP=1, ld_x -> base_x=144; next ld_x -> dir=left, base_x=143; from base_x=0 moving left, ld_x -> base_x=1, dir=right.
//  5. stop_in 0->1, then ld_x=ld_y=1 -> base_x=0, y=112, stop_true=0; stop_in held high -> no second request.
//  6. Stop at base_y=0 -> game_over=1, y stays 0; further stop_in edges are ignored; reset_load=0 clears game_over and restores y=116.

Source files
------------

// File: rtl/stacker_pkg.sv
// Shared widths, colour constants and direction encoding for the stacker game datapath.
package stacker_pkg;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W          = 8;
  localparam int Y_W          = 7;
  localparam int DCNT_W       = 20;

  localparam logic [2:0] BLACK = 3'b000;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

endpackage

// File: rtl/stacker_datapath_pixel_counter.sv
// Walks px across the block row by row, flagging the final pixel of a pass.
module block_pixel_counter #(
  parameter int BLOCK_W = 16,
  parameter int BLOCK_H = 4,
  localparam int PX_W = $clog2(BLOCK_W),
  localparam int PY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clr_n,
  input  logic            en,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last
);

  localparam logic [PX_W-1:0] PX_LAST = PX_W'(BLOCK_W - 1);
  localparam logic [PY_W-1:0] PY_LAST = PY_W'(BLOCK_H - 1);

  logic [PX_W-1:0] px_q, px_d;
  logic [PY_W-1:0] py_q, py_d;

  // Final pixel of the pass; suppressed while either reset is asserted.
  assign last = resetn & clr_n & en & (px_q == PX_LAST) & (py_q == PY_LAST);

  // Next pixel position: idle or final pixel returns to the origin.
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (!en || last) begin
      px_d = '0;
      py_d = '0;
    end else if (px_q == PX_LAST) begin
      px_d = '0;
      py_d = py_q + PY_W'(1);
    end else begin
      px_d = px_q + PX_W'(1);
    end
  end

  // Counter registers; either reset aborts a pass mid-block.
  always_ff @(posedge clk) begin
    if (!resetn || !clr_n) begin
      px_q <= '0;
      py_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
    end
  end

  assign px = px_q;
  assign py = py_q;

endmodule

// File: rtl/stacker_datapath.sv
// Execution stage beneath the stacker FSM: block position, frame delay, pixel walk and stop latch.
module stacker_datapath
  import stacker_pkg::*;
#(
  parameter int BLOCK_W   = 16,
  parameter int BLOCK_H   = 4,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int X_STEP    = 1,
  parameter int FRAME_DIV = 833333
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           reset_counter,
  input  logic           enable_counter,
  input  logic           reset_load,
  input  logic           ld_x,
  input  logic           ld_y,
  input  logic           count_x_enable,
  input  logic           colour_erase_enable,
  input  logic           stop_in,
  input  logic [2:0]     colour_in,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           done_plot,
  output logic           enable_erase,
  output logic           stop_true,
  output logic           game_over
);

  localparam int PX_W = $clog2(BLOCK_W);
  localparam int PY_W = (BLOCK_H > 1) ? $clog2(BLOCK_H) : 1;

  localparam logic [X_W-1:0]    STEP_X    = X_W'(X_STEP);
  localparam logic [X_W:0]      RIGHT_LIM = (X_W+1)'(SCREEN_W - BLOCK_W - X_STEP);
  localparam logic [Y_W-1:0]    BH_Y      = Y_W'(BLOCK_H);
  localparam logic [Y_W-1:0]    Y_START   = Y_W'(SCREEN_H - BLOCK_H);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(FRAME_DIV - 1);

  logic              run;
  logic [PX_W-1:0]   px;
  logic [PY_W-1:0]   py;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              stop_dly_q, stop_rise;
  logic              stop_req_q, stop_req_d;
  logic [X_W-1:0]    base_x_q, base_x_d;
  logic [Y_W-1:0]    base_y_q, base_y_d;
  dir_e              dir_q, dir_d;
  logic              game_over_q, game_over_d;

  assign run = resetn & reset_load;

  block_pixel_counter #(
    .BLOCK_W (BLOCK_W),
    .BLOCK_H (BLOCK_H)
  ) u_pix (
    .clk    (clk),
    .resetn (resetn),
    .clr_n  (reset_load),
    .en     (count_x_enable),
    .px     (px),
    .py     (py),
    .last   (done_plot)
  );

  // Frame-delay counter: wraps at FRAME_DIV-1, pulsing enable_erase on that cycle.
  always_comb begin
    dcnt_d = dcnt_q;
    if (enable_counter) dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + DCNT_W'(1);
  end

  assign enable_erase = resetn & reset_counter & enable_counter & (dcnt_q == DCNT_LAST);

  // Delay counter register; local clear takes priority over counting.
  always_ff @(posedge clk) begin
    if (!resetn || !reset_counter) dcnt_q <= '0;
    else                           dcnt_q <= dcnt_d;
  end

  // Delayed copy of the button for edge detection; it tracks through reset so a held button never fakes an edge.
  always_ff @(posedge clk) begin
    stop_dly_q <= stop_in;
  end

  assign stop_rise = stop_in & ~stop_dly_q;

  // Stop request: a new edge beats a simultaneous ld_y clear; edges are ignored after game over.
  always_comb begin
    stop_req_d = stop_req_q;
    if (stop_rise && !game_over_q) stop_req_d = 1'b1;
    else if (ld_y)                 stop_req_d = 1'b0;
  end

  // Position update: a consumed stop drops the block a row, otherwise ld_x sweeps and bounces.
  always_comb begin
    base_x_d    = base_x_q;
    base_y_d    = base_y_q;
    dir_d       = dir_q;
    game_over_d = game_over_q;
    if (stop_req_q && ld_y) begin
      base_x_d = '0;
      dir_d    = DIR_RIGHT;
      if (base_y_q >= BH_Y) base_y_d    = base_y_q - BH_Y;
      else                  game_over_d = 1'b1;
    end else if (!stop_req_q && ld_x) begin
      if (dir_q == DIR_RIGHT) begin
        if ({1'b0, base_x_q} <= RIGHT_LIM) begin
          base_x_d = base_x_q + STEP_X;
        end else begin
          dir_d    = DIR_LEFT;
          base_x_d = base_x_q - STEP_X;
        end
      end else begin
        if (base_x_q >= STEP_X) begin
          base_x_d = base_x_q - STEP_X;
        end else begin
          dir_d    = DIR_RIGHT;
          base_x_d = base_x_q + STEP_X;
        end
      end
    end
  end

  // Game state registers; either reset restores the start position.
  always_ff @(posedge clk) begin
    if (!run) begin
      base_x_q    <= '0;
      base_y_q    <= Y_START;
      dir_q       <= DIR_RIGHT;
      stop_req_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      base_x_q    <= base_x_d;
      base_y_q    <= base_y_d;
      dir_q       <= dir_d;
      stop_req_q  <= stop_req_d;
      game_over_q <= game_over_d;
    end
  end

  assign x         = run ? base_x_q + X_W'(px) : '0;
  assign y         = run ? base_y_q + Y_W'(py) : Y_START;
  assign colour    = colour_erase_enable ? BLACK : colour_in;
  assign stop_true = run & stop_req_q;
  assign game_over = run & game_over_q;

endmodule

// File: tb/tb_stacker_datapath.sv
// Directed bench for stacker_datapath: plot/erase passes, frame delay, sweep bounces, stop and game over.
module tb_stacker_datapath;

  logic       clk = 1'b0;
  logic       resetn, reset_counter, enable_counter, reset_load;
  logic       ld_x, ld_y, count_x_enable, colour_erase_enable, stop_in;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       done_plot, enable_erase, stop_true, game_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stacker_datapath #(
    .FRAME_DIV (5)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .reset_counter       (reset_counter),
    .enable_counter      (enable_counter),
    .reset_load          (reset_load),
    .ld_x                (ld_x),
    .ld_y                (ld_y),
    .count_x_enable      (count_x_enable),
    .colour_erase_enable (colour_erase_enable),
    .stop_in             (stop_in),
    .colour_in           (colour_in),
    .x                   (x),
    .y                   (y),
    .colour              (colour),
    .done_plot           (done_plot),
    .enable_erase        (enable_erase),
    .stop_true           (stop_true),
    .game_over           (game_over)
  );

  typedef struct {
    logic       rl, lx, ly, si;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       es, eg;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset_counter = 1'b1; enable_counter = 1'b0; reset_load = 1'b1;
    ld_x = 1'b0; ld_y = 1'b0; count_x_enable = 1'b0;
    colour_erase_enable = 1'b0; stop_in = 1'b0;
  endtask

  task automatic load_reset();
    reset_load = 1'b0;
    tick();
    reset_load = 1'b1;
  endtask

  task automatic do_stop();
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0; ld_y = 1'b1;
    tick();
    ld_y = 1'b0;
  endtask

  initial begin
    //              rl   lx   ly   si   x   y    stop go
    vecs[0]  = '{1'b1,1'b1,1'b0,1'b0, 1, 116, 1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b1,1'b0,1'b0, 2, 116, 1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b1, 2, 116, 1'b1,1'b0};
    vecs[3]  = '{1'b1,1'b1,1'b1,1'b1, 0, 112, 1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b1, 1, 112, 1'b0,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,1'b0, 1, 112, 1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b1, 1, 112, 1'b1,1'b0};
    vecs[7]  = '{1'b1,1'b0,1'b1,1'b1, 0, 108, 1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0, 0, 108, 1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b1,1'b1, 0, 108, 1'b1,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 0, 116, 1'b0,1'b0};

    idle_inputs();
    colour_in = 3'b101;
    resetn = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_x", x, 0);
    chk("rst_y", y, 116);
    chk("rst_done", done_plot, 0);
    chk("rst_erase", enable_erase, 0);
    chk("rst_stop", stop_true, 0);
    chk("rst_go", game_over, 0);
    chk("rst_colour", colour, 5);
    resetn = 1'b1;
    tick();

    // Plot pass
    count_x_enable = 1'b1;
    for (int k = 0; k < 64; k++) begin
      #1;
      chk($sformatf("plot_x%0d", k), x, k % 16);
      chk($sformatf("plot_y%0d", k), y, 116 + k / 16);
      chk($sformatf("plot_done%0d", k), done_plot, (k == 63) ? 1 : 0);
      chk($sformatf("plot_col%0d", k), colour, 5);
      tick();
    end
    #1;
    chk("plot_wrap_x", x, 0);
    chk("plot_wrap_y", y, 116);

    // Erase pass
    count_x_enable = 1'b0;
    tick();
    count_x_enable = 1'b1; colour_erase_enable = 1'b1; colour_in = 3'b011;
    for (int k = 0; k < 64; k++) begin
      #1;
      chk($sformatf("erase_col%0d", k), colour, 0);
      chk($sformatf("erase_x%0d", k), x, k % 16);
      chk($sformatf("erase_done%0d", k), done_plot, (k == 63) ? 1 : 0);
      tick();
    end
    count_x_enable = 1'b0; colour_erase_enable = 1'b0;
    #1;
    chk("col_restore", colour, 3);

    // Reset in mid-plot leaves no residual pixel offset
    count_x_enable = 1'b1;
    repeat (10) tick();
    chk("mid_x_pre", x, 10);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("abort_x", x, 0);
    chk("abort_y", y, 116);
    tick();
    chk("abort_next_x", x, 1);
    count_x_enable = 1'b0;
    tick();

    // Frame delay: pulses every 5 enabled cycles
    reset_counter = 1'b0;
    tick();
    reset_counter = 1'b1; enable_counter = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      #1;
      chk($sformatf("erase_pulse%0d", c), enable_erase, (c % 5 == 0) ? 1 : 0);
      tick();
    end
    reset_counter = 1'b0; enable_counter = 1'b0;
    tick();
    reset_counter = 1'b1; enable_counter = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      reset_counter = (c == 3) ? 1'b0 : 1'b1;
      #1;
      chk($sformatf("erase_clr%0d", c), enable_erase, (c == 8) ? 1 : 0);
      tick();
    end
    reset_counter = 1'b1; enable_counter = 1'b0;

    // Sweep bounce at both screen edges
    load_reset();
    ld_x = 1'b1;
    repeat (143) tick();
    chk("sweep_143", x, 143);
    tick();
    chk("sweep_144", x, 144);
    tick();
    chk("bounce_left", x, 143);
    repeat (143) tick();
    chk("sweep_0", x, 0);
    tick();
    chk("bounce_right", x, 1);
    tick();
    chk("after_bounce", x, 2);
    ld_x = 1'b0;
    chk("sweep_y", y, 116);

    // Stop/update sequence table
    load_reset();
    for (int i = 0; i < 11; i++) begin
      reset_load = vecs[i].rl; ld_x = vecs[i].lx; ld_y = vecs[i].ly; stop_in = vecs[i].si;
      tick();
      chk($sformatf("vec%0d_x", i), x, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), y, vecs[i].ey);
      chk($sformatf("vec%0d_stop", i), stop_true, vecs[i].es);
      chk($sformatf("vec%0d_go", i), game_over, vecs[i].eg);
    end
    idle_inputs();
    tick();

    // Stack to the top, then game over
    load_reset();
    for (int i = 0; i < 29; i++) do_stop();
    chk("top_y", y, 0);
    chk("top_go", game_over, 0);
    do_stop();
    chk("over_y", y, 0);
    chk("over_go", game_over, 1);
    stop_in = 1'b1;
    tick();
    chk("over_ignored", stop_true, 0);
    stop_in = 1'b0;
    tick();
    stop_in = 1'b1;
    tick();
    chk("over_ignored2", stop_true, 0);
    stop_in = 1'b0;
    chk("over_sticky", game_over, 1);
    load_reset();
    #1;
    chk("reload_go", game_over, 0);
    chk("reload_y", y, 116);
    chk("reload_x", x, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
